// File: rtl/game_ctrl_if.sv
// game_ctrl_if: groups the frame/sprite/button inputs and the game status
// outputs of game_ctrl.
//   master : video/sprite side; drives i_* and observes o_*.
//   slave  : game_ctrl; consumes i_* and drives o_*.
// Signals:
//   i_v_sync        vertical sync; 0->1 marks a frame boundary
//   i_pix_valid     current pixel is in the active area
//   i_penguin_hit   penguin sprite covers current pixel
//   i_glacier1_hit  glacier 1 sprite covers current pixel
//   i_glacier2_hit  glacier 2 sprite covers current pixel
//   i_btn_start     raw asynchronous start button
//   o_state         0=IDLE 1=PLAY 2=HIT 3=OVER
//   o_run           sprite motion enable
//   o_penguin_blank penguin suppressed (invulnerability blink)
//   o_lives         remaining lives
//   o_score         frames survived, saturating
//   o_frame_tick    one-cycle pulse per frame boundary
interface game_ctrl_if;
    logic        i_v_sync;
    logic        i_pix_valid;
    logic        i_penguin_hit;
    logic        i_glacier1_hit;
    logic        i_glacier2_hit;
    logic        i_btn_start;
    logic [1:0]  o_state;
    logic        o_run;
    logic        o_penguin_blank;
    logic [1:0]  o_lives;
    logic [13:0] o_score;
    logic        o_frame_tick;

    modport master (
        output i_v_sync, i_pix_valid, i_penguin_hit, i_glacier1_hit,
               i_glacier2_hit, i_btn_start,
        input  o_state, o_run, o_penguin_blank, o_lives, o_score, o_frame_tick
    );

    modport slave (
        input  i_v_sync, i_pix_valid, i_penguin_hit, i_glacier1_hit,
               i_glacier2_hit, i_btn_start,
        output o_state, o_run, o_penguin_blank, o_lives, o_score, o_frame_tick
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: frame-level game controller for the penguin/glacier display.
// Debounces the start button, detects frame boundaries from v_sync, latches
// penguin/glacier collisions within a frame and runs the game FSM
// (IDLE, PLAY, HIT/invulnerable, OVER). All outputs are registered.
// Ports:
//   i_clk  pixel clock
//   i_rst  synchronous active-high reset
//   bus    game_ctrl_if.slave (sprite/frame/button inputs, status outputs)
module game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int INVULN_FRAMES   = 90,
    parameter int START_LIVES     = 3,
    parameter int SCORE_MAX       = 9999
) (
    input  logic        i_clk,
    input  logic        i_rst,
    game_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    // button path
    logic             btn_meta, btn_sync, btn_deb, btn_deb_d, press;
    logic [CNT_W-1:0] deb_cnt;

    // frame / collision
    logic v_sync_d, frame_tick, coll_latch;

    // game state
    state_t      state, state_n;
    logic [1:0]  lives, lives_n;
    logic [13:0] score, score_n;
    logic [7:0]  inv, inv_n;
    logic        run, blank;

    function automatic logic [13:0] sat_inc(input logic [13:0] s);
        if (s >= 14'(SCORE_MAX))
            return 14'(SCORE_MAX);
        else
            return s + 14'd1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            btn_deb   <= 1'b0;
            btn_deb_d <= 1'b0;
            press     <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            btn_meta  <= bus.i_btn_start;
            btn_sync  <= btn_meta;
            // Counter measures how long the synchronized level has disagreed
            // with the accepted level; it is accepted on the last count.
            if (btn_sync == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_deb <= btn_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            btn_deb_d <= btn_deb;
            press     <= btn_deb & ~btn_deb_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_sync_d   <= 1'b0;
            frame_tick <= 1'b0;
            coll_latch <= 1'b0;
        end else begin
            v_sync_d   <= bus.i_v_sync;
            frame_tick <= bus.i_v_sync & ~v_sync_d;
            // Clearing on the tick takes priority, so a hit on that exact
            // cycle belongs to neither frame.
            if (frame_tick)
                coll_latch <= 1'b0;
            else if (bus.i_pix_valid & bus.i_penguin_hit &
                     (bus.i_glacier1_hit | bus.i_glacier2_hit) & ~blank)
                coll_latch <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        lives_n = lives;
        score_n = score;
        inv_n   = inv;
        case (state)
            S_IDLE: begin
                lives_n = 2'(START_LIVES);
                score_n = '0;
                inv_n   = '0;
                if (press)
                    state_n = S_PLAY;
            end
            S_PLAY: begin
                if (frame_tick) begin
                    if (coll_latch) begin
                        if (lives == 2'd1) begin
                            lives_n = 2'd0;
                            state_n = S_OVER;
                        end else begin
                            lives_n = lives - 2'd1;
                            inv_n   = 8'(INVULN_FRAMES);
                            state_n = S_HIT;
                        end
                    end else begin
                        score_n = sat_inc(score);
                    end
                end
            end
            S_HIT: begin
                if (frame_tick) begin
                    score_n = sat_inc(score);
                    inv_n   = inv - 8'd1;
                    if (inv == 8'd1)
                        state_n = S_PLAY;
                end
            end
            S_OVER: begin
                if (press) begin
                    lives_n = 2'(START_LIVES);
                    score_n = '0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // run/blank are registered from next-state values so they line up with state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            lives <= 2'(START_LIVES);
            score <= '0;
            inv   <= '0;
            run   <= 1'b0;
            blank <= 1'b0;
        end else begin
            state <= state_n;
            lives <= lives_n;
            score <= score_n;
            inv   <= inv_n;
            run   <= (state_n == S_PLAY) || (state_n == S_HIT);
            blank <= (state_n == S_HIT) && inv_n[3];
        end
    end

    assign bus.o_state         = state;
    assign bus.o_run           = run;
    assign bus.o_penguin_blank = blank;
    assign bus.o_lives         = lives;
    assign bus.o_score         = score;
    assign bus.o_frame_tick    = frame_tick;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench for game_ctrl. Each driven frame pushes the
// expected post-tick status computed by a frame-level game model; a monitor
// pops and compares it on the cycle after every o_frame_tick.
module tb_game_ctrl;
    localparam int DEB   = 4;
    localparam int INV   = 16;
    localparam int START = 3;
    localparam int SMAX  = 25;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_ctrl_if bus();

    game_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .INVULN_FRAMES  (INV),
        .START_LIVES    (START),
        .SCORE_MAX      (SMAX)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  lives;
        logic [13:0] score;
        logic        blank;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   ticks = 0;
    logic tick_prev = 1'b0;

    int m_st, m_lives, m_score, m_inv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int s);
        return (s >= SMAX) ? SMAX : s + 1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_lives = START; m_score = 0; m_inv = 0;
    endtask

    task automatic model_tick(input bit hit);
        exp_t e;
        case (m_st)
            1: begin
                if (hit) begin
                    if (m_lives == 1) begin
                        m_lives = 0; m_st = 3;
                    end else begin
                        m_lives = m_lives - 1; m_inv = INV; m_st = 2;
                    end
                end else begin
                    m_score = sat(m_score);
                end
            end
            2: begin
                m_score = sat(m_score);
                if (m_inv == 1) m_st = 1;
                m_inv = m_inv - 1;
            end
            default: ;
        endcase
        e.st    = 2'(m_st);
        e.lives = 2'(m_lives);
        e.score = 14'(m_score);
        e.blank = (m_st == 2) && (((m_inv >> 3) & 1) == 1);
        q.push_back(e);
    endtask

    // Monitor: status updates at the edge that samples o_frame_tick=1
    always @(negedge clk) begin
        if (tick_prev) begin
            chk("tick_expected", (q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("tick_state", bus.o_state, mon_e.st);
                chk("tick_lives", bus.o_lives, mon_e.lives);
                chk("tick_score", bus.o_score, mon_e.score);
                chk("tick_blank", bus.o_penguin_blank, mon_e.blank);
                chk("tick_run",   bus.o_run, (mon_e.st == 2'd1) || (mon_e.st == 2'd2));
            end
        end
        if (bus.o_frame_tick === 1'b1) ticks++;
        tick_prev = (bus.o_frame_tick === 1'b1) && (rst === 1'b0);
    end

    task automatic clear_pix();
        bus.i_pix_valid    = 1'b0;
        bus.i_penguin_hit  = 1'b0;
        bus.i_glacier1_hit = 1'b0;
        bus.i_glacier2_hit = 1'b0;
    endtask

    // mode: 0 no hit, 1 hit (glacier2), 2 hit without pix_valid,
    //       3 hit on the tick cycle, 4 hit (glacier1)
    task automatic frame(input int mode, input int vs_len);
        logic hitnow;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            hitnow = (i == 4) && (mode == 1 || mode == 2 || mode == 4);
            bus.i_pix_valid    = (mode != 2);
            bus.i_penguin_hit  = hitnow;
            bus.i_glacier1_hit = hitnow && (mode == 4);
            bus.i_glacier2_hit = hitnow && (mode != 4);
        end
        @(posedge clk); #1;
        clear_pix();
        model_tick(mode == 1 || mode == 4);
        bus.i_v_sync = 1'b1;
        for (int i = 1; i < vs_len; i++) begin
            @(posedge clk); #1;
            if (mode == 3 && i == 1) begin
                bus.i_pix_valid    = 1'b1;
                bus.i_penguin_hit  = 1'b1;
                bus.i_glacier1_hit = 1'b1;
            end else begin
                clear_pix();
            end
        end
        @(posedge clk); #1;
        clear_pix();
        bus.i_v_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input string tag);
        logic [1:0] old;
        int lat;
        old = bus.o_state;
        lat = 0;
        @(posedge clk); #1;
        bus.i_btn_start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (lat == 0 && bus.o_state !== old) lat = c;
            if (c == 10) bus.i_btn_start = 1'b0;
        end
        chk({tag, "_latency_7to9"}, (lat >= 7 && lat <= 9), 1);
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 3) begin
            m_st = 0; m_lives = START; m_score = 0;
        end
        chk({tag, "_state"}, bus.o_state, m_st);
        chk({tag, "_lives"}, bus.o_lives, m_lives);
        chk({tag, "_score"}, bus.o_score, m_score);
        chk({tag, "_run"},   bus.o_run, (m_st == 1 || m_st == 2));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, bus.o_state, 0);
        chk({tag, "_lives"}, bus.o_lives, START);
        chk({tag, "_score"}, bus.o_score, 0);
        chk({tag, "_run"},   bus.o_run, 0);
        chk({tag, "_blank"}, bus.o_penguin_blank, 0);
        chk({tag, "_tick"},  bus.o_frame_tick, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        bus.i_v_sync    = 1'b0;
        bus.i_btn_start = 1'b0;
        clear_pix();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        // ticks in IDLE change nothing
        frame(0, 3);

        // 3-cycle glitch is rejected
        @(posedge clk); #1;
        bus.i_btn_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.i_btn_start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("glitch_state", bus.o_state, 0);

        press_btn("start");

        base = ticks;
        for (int i = 0; i < 5; i++) frame(0, 3);
        chk("five_ticks", ticks - base, 5);
        chk("five_score", bus.o_score, 5);
        frame(0, 100);
        chk("long_vsync_ticks", ticks - base, 6);

        // first collision, then collisions during invulnerability
        frame(1, 3);
        for (int i = 0; i < 16; i++) frame((i % 2 == 1) ? 1 : 4, 3);
        chk("after_hit_state", bus.o_state, 1);
        chk("after_hit_lives", bus.o_lives, 2);

        // second collision; score reaches saturation during HIT
        frame(4, 3);
        for (int i = 0; i < 16; i++) frame(0, 3);
        chk("saturated_score", bus.o_score, SMAX);

        // third collision ends the game
        frame(1, 3);
        chk("over_state", bus.o_state, 3);
        chk("over_run", bus.o_run, 0);
        frame(1, 3);
        frame(0, 3);

        press_btn("restart");
        press_btn("start2");

        frame(2, 3);
        frame(3, 3);
        frame(0, 3);
        chk("no_loss_lives", bus.o_lives, 3);
        frame(1, 3);
        frame(0, 3);
        frame(0, 3);
        chk("blank_before_reset", bus.o_penguin_blank, 1);

        // reset mid-HIT
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midreset");
        rst = 1'b0;
        model_reset();
        frame(0, 3);
        chk("post_reset_idle", bus.o_state, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
